fifo_sync_param: RTL and testbench

//   Parametrised single-clock FIFO; next generation of the 8x32 synchronous FIFO.

---
 rtl/fifo_sync_pkg.sv | 29 ++
 rtl/fifo_sync_mem.sv | 46 ++++
 rtl/fifo_sync_param.sv | 119 +++++++++++
 tb/tb_fifo_sync_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_sync_pkg;

   localparam int unsigned PTR_MAX_W = 32;

   // Wide container for pointer/count arithmetic in threshold checks
   typedef logic [PTR_MAX_W-1:0] fifo_ptr_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   // Pointer width: index bits plus one wrap bit
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic cnt_ge(input fifo_ptr_t cnt, input fifo_ptr_t th);
      return cnt >= th;
   endfunction

   function automatic logic cnt_le(input fifo_ptr_t cnt, input fifo_ptr_t th);
      return cnt <= th;
   endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// FIFO storage array, one write port and one read port.
// FIFO_SYNC_FWFT_EN selects an asynchronous read port instead of the registered one.
module fifo_sync_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AW     = 3
) (
   input  logic              clk,
`ifndef FIFO_SYNC_FWFT_EN
   input  logic              reset,
`endif
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

`ifdef FIFO_SYNC_FWFT_EN
   assign rd_data = rd_en ? mem_q[rd_addr] : '0;
`else
   logic [DATA_W-1:0] rd_data_q;

   // Non-blocking read sees the old word when read and write hit one address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds and error pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync_param
   import fifo_sync_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AFULL_TH = 6,
   parameter int unsigned AEMPT_TH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          d_in,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          d_out,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = ptr_w(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count_q, count_d;
   fifo_flags_t      flags_q, flags_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             rd_valid_q, rd_valid_d;
   logic             wr_ok_c, rd_ok_c;
   logic             mem_rd_en_c;

   // Flags are registered from next-state pointers so they always match the pointer registers
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ok_c     = en & wr_en & ~flags_q.full;
      rd_ok_c     = en & rd_en & ~flags_q.empty;
      overflow_d  = en & wr_en & flags_q.full;
      underflow_d = en & rd_en & flags_q.empty;

      if (wr_ok_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d               = wr_ptr_d - rd_ptr_d;
      flags_d.full          = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      flags_d.empty         = (wr_ptr_d == rd_ptr_d);
      flags_d.almost_full   = cnt_ge(fifo_ptr_t'(count_d), fifo_ptr_t'(AFULL_TH));
      flags_d.almost_empty  = cnt_le(fifo_ptr_t'(count_d), fifo_ptr_t'(AEMPT_TH));

`ifdef FIFO_SYNC_FWFT_EN
      rd_valid_d  = ~flags_d.empty;
      mem_rd_en_c = ~flags_q.empty;
`else
      rd_valid_d  = rd_ok_c;
      mem_rd_en_c = rd_ok_c;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         flags_q      <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         flags_q      <= flags_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   fifo_sync_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
`ifndef FIFO_SYNC_FWFT_EN
      .reset   (reset),
`endif
      .wr_en   (wr_ok_c),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (d_in),
      .rd_en   (mem_rd_en_c),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (d_out)
   );

   assign rd_valid     = rd_valid_q;
   assign full         = flags_q.full;
   assign empty        = flags_q.empty;
   assign almost_full  = flags_q.almost_full;
   assign almost_empty = flags_q.almost_empty;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: vector table plus queue-based reference model.
module tb_fifo_sync_param;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned AFULL_TH = 6;
   localparam int unsigned AEMPT_TH = 2;
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              wr_en;
   logic [DATA_W-1:0] d_in;
   logic              rd_en;
   logic [DATA_W-1:0] d_out;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   fifo_sync_param #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH),
      .AEMPT_TH (AEMPT_TH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .wr_en        (wr_en),
      .d_in         (d_in),
      .rd_en        (rd_en),
      .d_out        (d_out),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        wr;
      logic [31:0] din;
      logic        rd;
      logic [31:0] exp_count;
      logic        exp_ovf;
      logic        exp_udf;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] model_q[$];
   logic [31:0] sb_q[$];
   logic [31:0] last_dout;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(input logic e, input logic w, input logic [31:0] d, input logic r,
                               input logic [31:0] c, input logic o, input logic u);
      vec_t v;
      v.en = e; v.wr = w; v.din = d; v.rd = r;
      v.exp_count = c; v.exp_ovf = o; v.exp_udf = u;
      return v;
   endfunction

   // One clock of stimulus, checked against the queue model
   task automatic cycle(input logic e, input logic w, input logic [31:0] din, input logic r);
      bit full_m, empty_m, wr_ok, rd_ok, ovf_m, udf_m;
      int sz;
      @(negedge clk);
      en = e; wr_en = w; d_in = din; rd_en = r;
      sz      = model_q.size();
      full_m  = (sz == DEPTH);
      empty_m = (sz == 0);
      wr_ok   = e && w && !full_m;
      rd_ok   = e && r && !empty_m;
      ovf_m   = e && w && full_m;
      udf_m   = e && r && empty_m;
      if (rd_ok) sb_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(din);
`ifdef FIFO_SYNC_FWFT_EN
      #1;
      chk("fwft_valid", 32'(rd_valid), 32'(!empty_m));
      if (rd_ok) chk("fwft_dout", d_out, sb_q.pop_front());
      else if (empty_m) chk("fwft_dout_empty", d_out, 32'h0);
`endif
      @(posedge clk);
      #1;
      sz = model_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= AFULL_TH));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AEMPT_TH));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("underflow", 32'(underflow), 32'(udf_m));
`ifndef FIFO_SYNC_FWFT_EN
      chk("rd_valid", 32'(rd_valid), 32'(rd_ok));
      if (rd_ok) last_dout = sb_q.pop_front();
      chk("d_out", d_out, last_dout);
`endif
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
      last_dout = '0;

      for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 1, 32'hA0 + 32'(i), 0, 32'(i + 1), 0, 0));
      vecs.push_back(mk(1, 1, 32'hFF, 0, 8, 1, 0));
      vecs.push_back(mk(1, 0, 32'h0, 0, 8, 0, 0));
      for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 32'h0, 1, 32'(7 - i), 0, 0));
      vecs.push_back(mk(1, 0, 32'h0, 1, 0, 0, 1));
      vecs.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 32'hB0 + 32'(i), 0, 32'(i + 1), 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_aempty", 32'(almost_empty), 32'h1);
      chk("rst_afull", 32'(almost_full), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      chk("rst_udf", 32'(underflow), 32'h0);
      chk("rst_valid", 32'(rd_valid), 32'h0);
      chk("rst_dout", d_out, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         cycle(vecs[i].en, vecs[i].wr, vecs[i].din, vecs[i].rd);
         chk("vec_count", 32'(count), vecs[i].exp_count);
         chk("vec_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
         chk("vec_udf", 32'(underflow), 32'(vecs[i].exp_udf));
      end

      // Simultaneous read/write at count 3: pointers wrap, occupancy steady
      for (int i = 0; i < 20; i++) begin
         cycle(1, 1, 32'hC0 + 32'(i), 1);
         chk("wrap_count", 32'(count), 32'h3);
      end

      // Enable low freezes everything at count 4
      cycle(1, 1, 32'hE0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 32'hEE, 1);
         chk("en0_count", 32'(count), 32'h4);
         chk("en0_ovf", 32'(overflow), 32'h0);
         chk("en0_udf", 32'(underflow), 32'h0);
      end

      // Full with read and write: read wins, write rejected
      for (int i = 1; i <= 4; i++) cycle(1, 1, 32'hE0 + 32'(i), 0);
      chk("full_flag", 32'(full), 32'h1);
      cycle(1, 1, 32'hF9, 1);
      chk("full_rw_count", 32'(count), 32'h7);
      chk("full_rw_ovf", 32'(overflow), 32'h1);

      // Asynchronous reset mid-burst at count 5
      cycle(1, 0, 32'h0, 1);
      cycle(1, 0, 32'h0, 1);
      chk("pre_rst_count", 32'(count), 32'h5);
      @(negedge clk);
      en = 1'b1; wr_en = 1'b1; d_in = 32'h77; rd_en = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_empty", 32'(empty), 32'h1);
      chk("mid_rst_dout", d_out, 32'h0);
      chk("mid_rst_valid", 32'(rd_valid), 32'h0);
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      reset = 1'b1;
      model_q.delete();
      sb_q.delete();
      last_dout = '0;
      cycle(1, 1, 32'hD0, 0);
      cycle(1, 0, 32'h0, 1);
      cycle(1, 0, 32'h0, 0);
`ifndef FIFO_SYNC_FWFT_EN
      chk("post_rst_data", d_out, 32'hD0);
`endif
      chk("post_rst_empty", 32'(empty), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
